// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: byte link between the SPI slave datapath and the register command controller
interface spi_reg_ctrl_if #(
    parameter int NUM_REGS = 8
);
    logic                  frame_active;
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic [7:0]            tx_byte;
    logic                  tx_load;
    logic                  wr_strobe;
    logic [6:0]            wr_addr;
    logic [7:0]            wr_data;
    logic [NUM_REGS*8-1:0] reg_out;
    logic                  led;
    logic                  err;

    modport slave (
        input  frame_active, rx_valid, rx_byte,
        output tx_byte, tx_load, wr_strobe, wr_addr, wr_data, reg_out, led, err
    );

    modport master (
        output frame_active, rx_valid, rx_byte,
        input  tx_byte, tx_load, wr_strobe, wr_addr, wr_data, reg_out, led, err
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI frame command sequencer onto a small register bank (SPI_REG_AUTOINC_EN enables address auto-increment)
module spi_reg_ctrl #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] ID_BYTE  = 8'hA5
) (
    input logic           clk,
    input logic           rst,
    spi_reg_ctrl_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    tx_byte_q;
    logic          tx_load_q;
    logic          wr_strobe_q;
    logic [6:0]    wr_addr_q;
    logic [7:0]    wr_data_q;
    logic          err_q;

    logic [6:0]    cmd_addr;
    logic [AW-1:0] cmd_idx;
    logic          cmd_ok;
    logic [AW-1:0] addr_d;
    logic [AW-1:0] cmd_next_d;

    assign cmd_addr = bus.rx_byte[6:0];
    assign cmd_idx  = cmd_addr[AW-1:0];
    assign cmd_ok   = int'(cmd_addr) < NUM_REGS;

`ifdef SPI_REG_AUTOINC_EN
    localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
    assign addr_d     = (addr_q == LAST) ? '0 : addr_q + AW'(1);
    assign cmd_next_d = (cmd_idx == LAST) ? '0 : cmd_idx + AW'(1);
`else
    assign addr_d     = addr_q;
    assign cmd_next_d = cmd_idx;
`endif

    // Frame sequencer: command decode, register access and registered slave-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            tx_byte_q   <= ID_BYTE;
            tx_load_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            tx_load_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            if (!bus.frame_active) begin
                if (state_q != IDLE) begin
                    state_q   <= IDLE;
                    tx_byte_q <= ID_BYTE;
                    tx_load_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: state_q <= CMD;
                    CMD: if (bus.rx_valid) begin
                        if (bus.rx_byte == 8'hFF) begin
                            err_q   <= 1'b0;
                            state_q <= DISCARD;
                        end else if (!cmd_ok) begin
                            err_q   <= 1'b1;
                            state_q <= DISCARD;
                        end else if (bus.rx_byte[7]) begin
                            addr_q  <= cmd_idx;
                            state_q <= WRITE;
                        end else begin
                            addr_q    <= cmd_next_d;
                            tx_byte_q <= regs_q[cmd_idx];
                            tx_load_q <= 1'b1;
                            state_q   <= READ;
                        end
                    end
                    WRITE: if (bus.rx_valid) begin
                        regs_q[addr_q] <= bus.rx_byte;
                        wr_strobe_q    <= 1'b1;
                        wr_addr_q      <= 7'(addr_q);
                        wr_data_q      <= bus.rx_byte;
                        tx_byte_q      <= bus.rx_byte;
                        tx_load_q      <= 1'b1;
                        addr_q         <= addr_d;
                    end
                    READ: if (bus.rx_valid) begin
                        tx_byte_q <= regs_q[addr_q];
                        tx_load_q <= 1'b1;
                        addr_q    <= addr_d;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign bus.reg_out[8*i +: 8] = regs_q[i];
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.tx_load   = tx_load_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.led       = regs_q[0][0];
    assign bus.err       = err_q;
endmodule
